// File: rtl/tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// tx_scheduler_if
//   Bundle between the byte requesters, the tx_scheduler and the UART tx.
//   Parameters NB_DATA / N_REQ must match the tx_scheduler instance.
//
//   i_req_valid  N_REQ          requester k has a byte to send
//   i_req_data   N_REQ*NB_DATA  byte of requester k at [k*NB_DATA +: NB_DATA]
//   o_req_ready  N_REQ          one-hot accept strobe (valid & ready = taken)
//   o_tx_valid   1              start pulse to tx i_valid
//   o_tx_data    NB_DATA        byte to tx i_data
//   o_grant      N_REQ          one-hot owner of current frame, 0 when idle
//   o_busy       1              frame in progress
//
//   master : requester/consumer side (drives requests, observes outputs)
//   slave  : tx_scheduler side
// ---------------------------------------------------------------------------
interface tx_scheduler_if #(
  parameter int NB_DATA = 8,
  parameter int N_REQ   = 2
);
  logic [N_REQ-1:0]         i_req_valid;
  logic [N_REQ*NB_DATA-1:0] i_req_data;
  logic [N_REQ-1:0]         o_req_ready;
  logic                     o_tx_valid;
  logic [NB_DATA-1:0]       o_tx_data;
  logic [N_REQ-1:0]         o_grant;
  logic                     o_busy;

  modport master (
    output i_req_valid, i_req_data,
    input  o_req_ready, o_tx_valid, o_tx_data, o_grant, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_data,
    output o_req_ready, o_tx_valid, o_tx_data, o_grant, o_busy
  );
endinterface

// File: rtl/tx_scheduler.sv
// ---------------------------------------------------------------------------
// tx_scheduler
//   Shares one UART transmitter between N_REQ byte requesters. One byte is
//   granted per frame, round-robin. Since tx reports no busy/done, the frame
//   length is measured here by counting TICKS_PER_BIT*FRAME_BITS baud ticks
//   after the start pulse.
//
//   Ports:
//     i_clk     clock
//     i_reset   synchronous, active-high reset (tx must share it)
//     i_tick    baud tick, 1-cycle pulse, same source as tx i_tick
//     bus       tx_scheduler_if.slave (requests, tx valid/data, grant, busy)
//
//   Configuration macro:
//     TX_SCHED_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                          rr pointer held at 0
//                             undefined -> round-robin (default)
//
//   FSM: IDLE (arbitrate/accept) -> ISSUE (1-cycle start pulse) -> WAIT
//   (count frame ticks) -> IDLE. o_req_ready is combinational; everything
//   else is registered.
// ---------------------------------------------------------------------------
module tx_scheduler #(
  parameter int NB_DATA       = 8,
  parameter int N_REQ         = 2,
  parameter int TICKS_PER_BIT = 16,
  parameter int FRAME_BITS    = NB_DATA + 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_tick,
  tx_scheduler_if.slave bus
);

  localparam int FRAME_TICKS = TICKS_PER_BIT * FRAME_BITS;
  localparam int CNT_W       = $clog2(FRAME_TICKS);
  localparam int PTR_W       = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_TICKS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [PTR_W-1:0]   rr_ptr_r;
  logic [PTR_W-1:0]   rr_ptr_nxt_s;
  logic [PTR_W-1:0]   winner_s;
  logic [CNT_W-1:0]   tick_cnt_r;
  logic [CNT_W-1:0]   tick_cnt_nxt_s;
  logic [NB_DATA-1:0] win_data_s;
  logic [NB_DATA-1:0] tx_data_nxt_s;
  logic [N_REQ-1:0]   win_onehot_s;
  logic [N_REQ-1:0]   grant_nxt_s;
  logic               any_valid_s;
  logic               tx_valid_nxt_s;
  logic               busy_nxt_s;
  int                 best_dist_s;
  int                 dist_s;

  // Arbiter: pick the valid requester closest to the rr pointer (distance
  // measured upward with wrap). With the pointer held at 0 this degenerates
  // to lowest-index-wins.
  always_comb begin
    winner_s    = {PTR_W{1'b0}};
    win_data_s  = {NB_DATA{1'b0}};
    best_dist_s = N_REQ;
    dist_s      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      dist_s = (k + N_REQ - int'(rr_ptr_r)) % N_REQ;
      if (bus.i_req_valid[k] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        winner_s    = PTR_W'(k);
        win_data_s  = bus.i_req_data[k*NB_DATA +: NB_DATA];
      end else begin
        best_dist_s = best_dist_s;
      end
    end
  end

  assign any_valid_s  = |bus.i_req_valid;
  assign win_onehot_s = ONE_HOT_0 << winner_s;

  // Ready only while idle, so a new byte can never overlap a running frame.
  assign bus.o_req_ready = ((state_r == ST_IDLE) && any_valid_s) ? win_onehot_s
                                                                 : {N_REQ{1'b0}};

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (i_tick && (tick_cnt_r == CNT_LAST)) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output / datapath next values (registered in the block below).
  always_comb begin
    tx_valid_nxt_s = (next_state_s == ST_ISSUE);
    busy_nxt_s     = (next_state_s != ST_IDLE);
    tx_data_nxt_s  = bus.o_tx_data;
    grant_nxt_s    = bus.o_grant;
    rr_ptr_nxt_s   = rr_ptr_r;
    tick_cnt_nxt_s = tick_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          tx_data_nxt_s = win_data_s;
          grant_nxt_s   = win_onehot_s;
`ifdef TX_SCHED_FIXED_PRIO_EN
          rr_ptr_nxt_s  = {PTR_W{1'b0}};
`else
          rr_ptr_nxt_s  = (winner_s == PTR_LAST) ? {PTR_W{1'b0}}
                                                 : winner_s + PTR_W'(1'b1);
`endif
        end else begin
          tx_data_nxt_s = bus.o_tx_data;
        end
      end
      // A tick coinciding with the start pulse belongs to no bit period yet.
      ST_ISSUE: tick_cnt_nxt_s = {CNT_W{1'b0}};
      ST_WAIT: begin
        if (i_tick) begin
          if (tick_cnt_r == CNT_LAST) begin
            tick_cnt_nxt_s = {CNT_W{1'b0}};
            grant_nxt_s    = {N_REQ{1'b0}};
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + CNT_W'(1'b1);
          end
        end else begin
          tick_cnt_nxt_s = tick_cnt_r;
        end
      end
      default: begin
        tick_cnt_nxt_s = {CNT_W{1'b0}};
        grant_nxt_s    = {N_REQ{1'b0}};
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r        <= ST_IDLE;
      rr_ptr_r       <= {PTR_W{1'b0}};
      tick_cnt_r     <= {CNT_W{1'b0}};
      bus.o_tx_valid <= 1'b0;
      bus.o_tx_data  <= {NB_DATA{1'b0}};
      bus.o_grant    <= {N_REQ{1'b0}};
      bus.o_busy     <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      rr_ptr_r       <= rr_ptr_nxt_s;
      tick_cnt_r     <= tick_cnt_nxt_s;
      bus.o_tx_valid <= tx_valid_nxt_s;
      bus.o_tx_data  <= tx_data_nxt_s;
      bus.o_grant    <= grant_nxt_s;
      bus.o_busy     <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_scheduler
//   Randomized bench for tx_scheduler. A reference model tracks frames as
//   "cycles since acceptance" plus "ticks seen since the start pulse" and a
//   circular round-robin walk over requesters; it checks ready/busy/grant/
//   tx_valid/tx_data every cycle and pushes the expected byte+grant into a
//   scoreboard that a separate monitor pops on each tx_valid pulse.
// ---------------------------------------------------------------------------
module tb_tx_scheduler;

  localparam int NB  = 8;
  localparam int NR  = 2;
  localparam int TPB = 16;
  localparam int FB  = NB + 2;
  localparam int FT  = TPB * FB;

  typedef struct packed {
    logic [NR-1:0] grant;
    logic [NB-1:0] data;
  } exp_t;

  logic clk     = 1'b0;
  logic i_reset = 1'b1;
  logic i_tick;

  tx_scheduler_if #(.NB_DATA(NB), .N_REQ(NR)) bus ();

  tx_scheduler #(
    .NB_DATA      (NB),
    .N_REQ        (NR),
    .TICKS_PER_BIT(TPB),
    .FRAME_BITS   (FB)
  ) dut (
    .i_clk  (clk),
    .i_reset(i_reset),
    .i_tick (i_tick),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus state
  logic [NB-1:0] pend [NR][$];
  bit            drv_valid [NR];
  int            tick_div = 0;
  bit            withdraw = 1'b0;
  bit            model_on = 1'b0;

  // reference model state
  int            m_age   = -1;   // -1 idle, 1 = start-pulse cycle, >=2 waiting
  int            m_rr    = 0;
  int            m_ticks = 0;
  int            m_owner = 0;
  logic [NB-1:0] m_data  = '0;

  exp_t          sb [$];
  logic [NB-1:0] obs [$];
  exp_t          mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int k);
    logic [NR-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int k = 0; k < NR; k++) if (pend[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  // one model step: check the current cycle, then advance with this cycle's inputs
  task automatic model_step();
    int            w;
    logic [NR-1:0] e_ready;
    logic [NR-1:0] e_grant;
    w = -1;
    for (int i = 0; i < NR; i++)
      if (w < 0 && drv_valid[(m_rr + i) % NR]) w = (m_rr + i) % NR;
    e_grant = (m_age >= 1) ? onehot(m_owner) : '0;
    e_ready = (m_age < 0 && w >= 0) ? onehot(w) : '0;
    check("busy",     32'(bus.o_busy),      32'(m_age >= 1));
    check("tx_valid", 32'(bus.o_tx_valid),  32'(m_age == 1));
    check("grant",    32'(bus.o_grant),     32'(e_grant));
    check("ready",    32'(bus.o_req_ready), 32'(e_ready));
    check("tx_data",  32'(bus.o_tx_data),   32'(m_data));
    if (i_reset) begin
      m_age = -1; m_rr = 0; m_ticks = 0; m_data = '0;
    end else if (m_age < 0) begin
      if (w >= 0) begin
        m_owner = w;
        m_data  = pend[w][0];
        sb.push_back('{grant: onehot(w), data: pend[w][0]});
        void'(pend[w].pop_front());
        m_age   = 1;
        m_ticks = 0;
`ifdef TX_SCHED_FIXED_PRIO_EN
        m_rr    = 0;
`else
        m_rr    = (w + 1) % NR;
`endif
      end
    end else if (m_age >= 2 && i_tick) begin
      m_ticks++;
      if (m_ticks == FT) m_age = -1;
      else m_age++;
    end else begin
      m_age++;
    end
  endtask

  // driver: ticks and request lines, updated just after each rising edge
  initial begin
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    i_tick          = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      i_tick = (tick_div == 0) ? 1'b0 :
               (tick_div == 1) ? 1'b1 : ($urandom_range(tick_div - 1, 0) == 0);
      for (int k = 0; k < NR; k++) begin
        drv_valid[k] = (pend[k].size() > 0) && (!withdraw || ($urandom_range(3, 0) != 0));
        bus.i_req_valid[k] = drv_valid[k];
        bus.i_req_data[k*NB +: NB] = (pend[k].size() > 0) ? pend[k][0] : NB'($urandom);
      end
    end
  end

  // reference model
  initial forever begin
    @(negedge clk);
    if (model_on) model_step();
  end

  // scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (model_on && bus.o_tx_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: tx_valid with data 0x%0h, nothing expected", bus.o_tx_data);
      end else begin
        mon_e = sb.pop_front();
        check("sb_data",  32'(bus.o_tx_data), 32'(mon_e.data));
        check("sb_grant", 32'(bus.o_grant),   32'(mon_e.grant));
      end
      obs.push_back(bus.o_tx_data);
    end
  end

  task automatic wait_idle(input int budget, input string name);
    int c;
    c = 0;
    while ((!all_empty() || m_age >= 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    check({name, "_timeout"}, 32'(c >= budget), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 i_reset = 1'b1;
    @(posedge clk); #1 i_reset = 1'b0;
  endtask

  logic [8:0]    line_v;
  logic [NB-1:0] exp_order [4];
  int            c;

  initial begin
`ifdef TX_SCHED_FIXED_PRIO_EN
    exp_order = '{8'h11, 8'h11, 8'h11, 8'h11};
`else
    exp_order = '{8'h11, 8'h22, 8'h11, 8'h22};
`endif
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    model_on = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_busy",     32'(bus.o_busy),      32'd0);
    check("rst_tx_valid", 32'(bus.o_tx_valid),  32'd0);
    check("rst_grant",    32'(bus.o_grant),     32'd0);
    check("rst_tx_data",  32'(bus.o_tx_data),   32'd0);
    check("rst_ready",    32'(bus.o_req_ready), 32'd0);

    // 200 ticks with no requests
    tick_div = 1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("idle_busy",  32'(bus.o_busy),      32'd0);
    check("idle_ready", 32'(bus.o_req_ready), 32'd0);
    check("idle_no_tx", 32'(obs.size()),      32'd0);

    // single byte 0xA5 from requester 0, tick on every cycle (incl. start pulse)
    @(posedge clk);
    pend[0].push_back(8'hA5);
    wait_idle(1000, "a5");
    check("a5_count", 32'(obs.size()), 32'd1);
    if (obs.size() > 0) begin
      line_v[0] = 1'b0;
      for (int i = 0; i < NB; i++) line_v[i+1] = obs[0][i];
      check("a5_line", 32'(line_v), 32'(9'b101001010));
    end

    // two requesters held valid, pointer restarted at 0
    pulse_reset();
    obs.delete();
    for (int i = 0; i < 4; i++) begin
      pend[0].push_back(8'h11);
      pend[1].push_back(8'h22);
    end
    wait_idle(5000, "rr");
    check("rr_count", 32'(obs.size()), 32'd8);
    if (obs.size() >= 4)
      for (int i = 0; i < 4; i++) check("rr_order", 32'(obs[i]), 32'(exp_order[i]));

    // requester 1 arrives while requester 0's frame is running
    tick_div = 2;
    obs.delete();
    @(posedge clk);
    pend[0].push_back(8'h3C);
    c = 0;
    while (m_age < 10 && c < 100) begin @(posedge clk); c++; end
    check("ovl_start_timeout", 32'(c >= 100), 32'd0);
    pend[1].push_back(8'hC3);
    wait_idle(3000, "ovl");
    check("ovl_count", 32'(obs.size()), 32'd2);
    if (obs.size() >= 2) begin
      check("ovl_first",  32'(obs[0]), 32'h3C);
      check("ovl_second", 32'(obs[1]), 32'hC3);
    end

    // reset around tick 50 of a frame, then a full frame must follow
    tick_div = 1;
    @(posedge clk);
    pend[0].push_back(8'h5A);
    c = 0;
    while (!(m_age >= 2 && m_ticks >= 50) && c < 200) begin @(posedge clk); c++; end
    check("mid_rst_timeout", 32'(c >= 200), 32'd0);
    #1 i_reset = 1'b1;
    @(posedge clk); #1 i_reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",  32'(bus.o_busy),  32'd0);
    check("mid_rst_grant", 32'(bus.o_grant), 32'd0);
    pend[1].push_back(8'h96);
    wait_idle(1000, "post_rst");

    // randomized traffic with request withdrawal and varying tick density
    withdraw = 1'b1;
    for (int r = 0; r < 8; r++) begin
      tick_div = $urandom_range(3, 1);
      for (int k = 0; k < NR; k++)
        repeat ($urandom_range(2, 0)) pend[k].push_back(NB'($urandom));
      wait_idle(4000, "rand");
    end
    withdraw = 1'b0;

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
